mpc_bank_arbiter: RTL and testbench

//  Per-bank request scheduler in front of each bank HTU port of the crossbar.
//  - Arbitrates the NUM_CH upstream channel request buses round-robin onto one bank request port.
//  - Gates issue on a bank credit counter that is refilled by the bank's crdt_rtn.
//  - Registers the granted request; bank_ch_id lets the return path route the response.
//  - One instance per bank; replaces per-bank arbitration inside the crossbar.

---
 rtl/mpc_types.sv | 25 ++
 rtl/mpc_rr_pick.sv | 29 ++
 rtl/mpc_bank_arbiter.sv | 115 +++++++++++
 tb/tb_mpc_bank_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_types.sv
// rtl/mpc_types.sv - shared request types and constants for the bank arbiter
package mpc_types;

    localparam int MPC_NUM_CH  = 3;
    localparam int MPC_CH_ID_W = 2;

    typedef enum logic [1:0] {
        MPC_OP_LOAD   = 2'd0,
        MPC_OP_STORE  = 2'd1,
        MPC_OP_ATOMIC = 2'd2,
        MPC_OP_FLUSH  = 2'd3
    } mpc_op_e;

    typedef struct packed {
        mpc_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } channel_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mpc_rr_pick.sv
// rtl/mpc_rr_pick.sv - combinational round-robin picker starting the scan at ptr
module mpc_rr_pick
    import mpc_types::*;
#(
    parameter int N = MPC_NUM_CH
) (
    input  logic [N-1:0]           req,
    input  logic [MPC_CH_ID_W-1:0] ptr,
    output logic [N-1:0]           gnt,
    output logic [MPC_CH_ID_W-1:0] idx,
    output logic                   any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (int'(ptr) + i) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = MPC_CH_ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/mpc_bank_arbiter.sv
// rtl/mpc_bank_arbiter.sv - credit-gated round-robin bank request scheduler; MPC_BANK_ARB_PERF_EN adds perf counters
module mpc_bank_arbiter
    import mpc_types::*;
#(
    parameter int NUM_CH     = MPC_NUM_CH,
    parameter int CRDT_MAX   = 4,
    parameter int CRDT_RTN_W = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               ch_req_valid,
    output logic [NUM_CH-1:0]               ch_req_ready,
    input  channel_req_t                    ch_req [NUM_CH],
    output logic                            bank_valid,
    input  logic                            bank_ready,
    output channel_req_t                    bank_req,
    output logic [MPC_CH_ID_W-1:0]          bank_ch_id,
    input  logic [CRDT_RTN_W-1:0]           crdt_rtn,
    output logic [$clog2(CRDT_MAX+1)-1:0]   crdt_avail,
    output logic                            crdt_ovf
`ifdef MPC_BANK_ARB_PERF_EN
    ,
    output logic [15:0]                     perf_grant_cnt [NUM_CH],
    output logic [15:0]                     perf_stall_cnt
`endif
);

    localparam int CW = $clog2(CRDT_MAX + 1);
    localparam int SW = CW + CRDT_RTN_W + 1;

    arb_state_e               state;
    arb_state_e               state_next;
    logic [NUM_CH-1:0]        pick_gnt;
    logic [MPC_CH_ID_W-1:0]   pick_idx;
    logic                     pick_any;
    logic [MPC_CH_ID_W-1:0]   rr_ptr;
    logic                     can_issue;
    logic                     grant;
    logic [SW-1:0]            crdt_sum;
    logic [CW-1:0]            crdt_next;
    logic                     ovf_hit;

    mpc_rr_pick #(.N(NUM_CH)) u_pick (
        .req (ch_req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The output register frees up in the same cycle the bank takes it.
    assign can_issue    = (state == ST_IDLE || bank_ready) && (crdt_avail != '0);
    assign grant        = rst_n && can_issue && pick_any;
    assign ch_req_ready = grant ? pick_gnt : '0;
    assign bank_valid   = (state == ST_HOLD);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant) state_next = ST_HOLD;
            ST_HOLD: if (bank_ready && !grant) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Wide enough to hold CRDT_MAX plus a full return before clamping.
    always_comb begin
        crdt_sum  = SW'(crdt_avail) + SW'(crdt_rtn) - SW'(grant);
        ovf_hit   = crdt_sum > SW'(CRDT_MAX);
        crdt_next = ovf_hit ? CW'(CRDT_MAX) : crdt_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bank_req   <= '0;
            bank_ch_id <= '0;
            rr_ptr     <= '0;
            crdt_avail <= CW'(CRDT_MAX);
            crdt_ovf   <= 1'b0;
        end else begin
            state      <= state_next;
            crdt_avail <= crdt_next;
            if (ovf_hit) begin
                crdt_ovf <= 1'b1;
            end
            if (grant) begin
                bank_req   <= ch_req[pick_idx];
                bank_ch_id <= pick_idx;
                rr_ptr     <= (pick_idx == MPC_CH_ID_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

`ifdef MPC_BANK_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                perf_grant_cnt[i] <= '0;
            end
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant && pick_gnt[i] && perf_grant_cnt[i] != 16'hFFFF) begin
                    perf_grant_cnt[i] <= perf_grant_cnt[i] + 16'd1;
                end
            end
            if ((|ch_req_valid) && (crdt_avail == '0) && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpc_bank_arbiter.sv
// tb/tb_mpc_bank_arbiter.sv - directed and randomized self-checking bench for mpc_bank_arbiter
module tb_mpc_bank_arbiter;
    import mpc_types::*;

    localparam int NCH  = 3;
    localparam int CMAX = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   ch_req_valid;
    logic [2:0]   ch_req_ready;
    channel_req_t ch_req [NCH];
    logic         bank_valid;
    logic         bank_ready;
    channel_req_t bank_req;
    logic [1:0]   bank_ch_id;
    logic [1:0]   crdt_rtn;
    logic [2:0]   crdt_avail;
    logic         crdt_ovf;
`ifdef MPC_BANK_ARB_PERF_EN
    logic [15:0]  perf_grant_cnt [NCH];
    logic [15:0]  perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    mpc_bank_arbiter #(.NUM_CH(NCH), .CRDT_MAX(CMAX), .CRDT_RTN_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req_valid (ch_req_valid),
        .ch_req_ready (ch_req_ready),
        .ch_req       (ch_req),
        .bank_valid   (bank_valid),
        .bank_ready   (bank_ready),
        .bank_req     (bank_req),
        .bank_ch_id   (bank_ch_id),
        .crdt_rtn     (crdt_rtn),
        .crdt_avail   (crdt_avail),
        .crdt_ovf     (crdt_ovf)
`ifdef MPC_BANK_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: one output slot, a credit pool, and a "next channel to favour".
    bit           m_full;
    channel_req_t m_req;
    int           m_id;
    int           m_crdt;
    int           m_ptr;
    bit           m_ovf;
    logic [2:0]   last_rdy;

    task automatic model_reset();
        m_full = 0;
        m_req  = '0;
        m_id   = 0;
        m_crdt = CMAX;
        m_ptr  = 0;
        m_ovf  = 0;
    endtask

    function automatic int model_winner();
        if ((m_full && !bank_ready) || m_crdt == 0) return -1;
        for (int k = 0; k < NCH; k++) begin
            int c = (m_ptr + k) % NCH;
            if (ch_req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(input int exp_rdy = -1);
        int         w;
        logic [2:0] er;
        @(negedge clk);
        w  = model_winner();
        er = (w >= 0) ? 3'(1 << w) : 3'b000;
        check_eq("ch_req_ready", 128'(ch_req_ready), 128'(er));
        if (exp_rdy >= 0) check_eq("directed_ready", 128'(ch_req_ready), 128'(exp_rdy));
        check_eq("bank_valid", 128'(bank_valid), 128'(m_full));
        if (m_full) begin
            check_eq("bank_req", 128'(bank_req), 128'(m_req));
            check_eq("bank_ch_id", 128'(bank_ch_id), 128'(m_id));
        end
        check_eq("crdt_avail", 128'(crdt_avail), 128'(m_crdt));
        check_eq("crdt_ovf", 128'(crdt_ovf), 128'(m_ovf));
        if (w >= 0) begin
            m_full = 1;
            m_req  = ch_req[w];
            m_id   = w;
            m_ptr  = (w + 1) % NCH;
            m_crdt = m_crdt - 1;
        end else if (m_full && bank_ready) begin
            m_full = 0;
        end
        m_crdt = m_crdt + int'(crdt_rtn);
        if (m_crdt > CMAX) begin
            m_crdt = CMAX;
            m_ovf  = 1;
        end
        last_rdy = ch_req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        for (int c = 0; c < NCH; c++) begin
            if (!ch_req_valid[c] || last_rdy[c]) begin
                ch_req_valid[c] = ($urandom_range(0, 99) < 60);
                ch_req[c].op    = mpc_op_e'($urandom_range(0, 3));
                ch_req[c].addr  = $urandom;
                ch_req[c].wdata = $urandom;
            end
        end
        bank_ready = ($urandom_range(0, 99) < 70);
        crdt_rtn   = ($urandom_range(0, 99) < 35) ? 2'($urandom_range(0, 3)) : 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        ch_req_valid = 3'b111;
        bank_ready   = 1'b0;
        crdt_rtn     = 2'd0;
        last_rdy     = 3'b000;
        for (int c = 0; c < NCH; c++) ch_req[c] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready_held_low", 128'(ch_req_ready), 128'(0));
        check_eq("rst_bank_req", 128'(bank_req), 128'(0));
        check_eq("rst_bank_ch_id", 128'(bank_ch_id), 128'(0));
        ch_req_valid = 3'b000;
        rst_n        = 1'b1;

        // Idle after reset
        step(0);
        step(0);

        // Return with the pool already full
        crdt_rtn = 2'd1;
        step(0);
        crdt_rtn = 2'd0;
        step(0);
        check_eq("full_return_ovf", 128'(crdt_ovf), 128'(1));
        check_eq("full_return_crdt", 128'(crdt_avail), 128'(CMAX));

        // All channels valid, bank always ready: drain the pool
        for (int c = 0; c < NCH; c++) begin
            ch_req[c].op    = MPC_OP_STORE;
            ch_req[c].addr  = 32'h1000 + 32'(c);
            ch_req[c].wdata = 32'hA0 + 32'(c);
        end
        ch_req_valid = 3'b111;
        bank_ready   = 1'b1;
        step(1);
        step(2);
        step(4);
        step(1);
        step(0);
        check_eq("drain_crdt_zero", 128'(crdt_avail), 128'(0));

        // Credit return at zero enables a grant only on the following cycle
        ch_req_valid = 3'b010;
        crdt_rtn     = 2'd2;
        step(0);
        crdt_rtn = 2'd0;
        step(2);
        ch_req_valid = 3'b000;
        step(0);
        check_eq("return_then_grant_crdt", 128'(crdt_avail), 128'(1));

        crdt_rtn = 2'd1;
        repeat (3) step(0);
        crdt_rtn = 2'd0;

        // Back-pressure holds the output register
        ch_req[2]    = '{op: MPC_OP_LOAD, addr: 32'h0000_0233, wdata: 32'h0};
        ch_req_valid = 3'b100;
        bank_ready   = 1'b0;
        step(4);
        ch_req_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step(0);
            check_eq("hold_ch_id", 128'(bank_ch_id), 128'(2));
            check_eq("hold_addr", 128'(bank_req.addr), 128'(32'h0000_0233));
        end
        bank_ready = 1'b1;
        step(1);

        // Asynchronous reset while holding a request
        bank_ready   = 1'b0;
        ch_req_valid = 3'b000;
        check_eq("pre_reset_valid", 128'(bank_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 128'(bank_valid), 128'(0));
        check_eq("async_rst_crdt", 128'(crdt_avail), 128'(CMAX));
        check_eq("async_rst_ovf", 128'(crdt_ovf), 128'(0));
`ifdef MPC_BANK_ARB_PERF_EN
        for (int c = 0; c < NCH; c++) check_eq("perf_grant_rst", 128'(perf_grant_cnt[c]), 128'(0));
        check_eq("perf_stall_rst", 128'(perf_stall_cnt), 128'(0));
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference
        last_rdy = 3'b000;
        repeat (600) begin
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
